// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer.
// Holds the opcode/funct values, the 4-bit ULA operation codes, the datapath
// select codes, the sequencer state encoding and small decode helpers that
// map an instruction to its legality and ULA configuration.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_SLT = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRL = 4'h6;
    localparam logic [3:0] ALU_LUI = 4'h7;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_ZIMM = 2'b01;
    localparam logic [1:0] SRCA_SIMM = 2'b10;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } ctrlState_t;

    // True for every instruction the sequencer knows how to run.
    function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_JR, FN_ADD,
                    FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                       legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    // ULA operation; address arithmetic for lw/sw falls through to ADD,
    // branches compare with SUB so the ULA zero flag decides the branch.
    function automatic logic [3:0] aluOpFor(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] aluOp;
        aluOp = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SUB:  aluOp = ALU_SUB;
                    FN_AND:  aluOp = ALU_AND;
                    FN_OR:   aluOp = ALU_OR;
                    FN_SLT:  aluOp = ALU_SLT;
                    FN_SLL:  aluOp = ALU_SLL;
                    FN_SRL:  aluOp = ALU_SRL;
                    default: aluOp = ALU_ADD;
                endcase
            end
            OP_BEQ, OP_BNE: aluOp = ALU_SUB;
            OP_SLTI:        aluOp = ALU_SLT;
            OP_ANDI:        aluOp = ALU_AND;
            OP_ORI:         aluOp = ALU_OR;
            OP_LUI:         aluOp = ALU_LUI;
            default:        aluOp = ALU_ADD;
        endcase
        return aluOp;
    endfunction

    // Logical immediates are zero-filled, arithmetic ones sign-extended.
    function automatic logic [1:0] srcAFor(input logic [5:0] op);
        logic [1:0] srcA;
        case (op)
            OP_ANDI, OP_ORI, OP_LUI:                       srcA = SRCA_ZIMM;
            OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE: srcA = SRCA_SIMM;
            default:                                       srcA = SRCA_REG;
        endcase
        return srcA;
    endfunction

    // Only the two shifts take their amount from the shamt field.
    function automatic logic srcBFor(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && ((fn == FN_SLL) || (fn == FN_SRL));
    endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Memory wait-state timer.
// Counts consecutive unacknowledged request cycles and flags the cycle in
// which the WAIT_MAX-th such cycle happens, so the sequencer can trap.
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous active-low reset
//   clear    return the count to zero
//   countEn  the current cycle is an unacknowledged request cycle
//   expired  this cycle is the WAIT_MAX-th unacknowledged cycle
module mips_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic countEn,
    output logic expired
);

    logic [WAIT_W-1:0] count;

    // Wait counter: cleared whenever no request is pending, bumped once per
    // cycle the request stays unacknowledged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (countEn) begin
            count <= count + 1'b1;
        end
    end

    // The count still holds WAIT_MAX-1 during the WAIT_MAX-th waiting cycle.
    assign expired = countEn && (count == WAIT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer driving PC, IR, register file, ULA and the
// unified memory through FETCH/DECODE/EXEC/MEM/WB, with a req/ack memory
// handshake, a bounded wait timeout and a sticky trap.
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   opcode, funct, zero      IR fields and ULA zero flag
//   mem_ack                  memory completes the pending request this cycle
//   mem_req, mem_we          memory request and write strobe
//   mem_addr_sel             0 = PC, 1 = ULA result
//   ir_we, pc_we, pc_src     IR load, PC load and PC source select
//   reg_we, reg_dst          register write enable and destination select
//   mem_to_reg               write-back data select
//   alu_src_a, alu_src_b     ULA operand selects
//   alu_op                   ULA operation
//   busy, trap, trap_cause   status (trap_cause: 0 illegal, 1 timeout)
//   state                    current sequencer state for debug
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 8,
    parameter int STATE_W  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic               alu_src_b,
    output logic [3:0]         alu_op,
    output logic               busy,
    output logic               trap,
    output logic               trap_cause,
    output logic [STATE_W-1:0] state
);

    ctrlState_t currentState;
    ctrlState_t nextState;
    logic       trapCause;
    logic       nextCause;
    logic       timerEn;
    logic       timerExpired;
    logic       isRType;

    assign isRType = (opcode == OP_RTYPE);

    // The timer runs only while a request is outstanding and unanswered; any
    // other cycle (including the ack cycle) rearms it for the next request.
    assign timerEn = ((currentState == FETCH) || (currentState == MEM)) && !mem_ack;

    mips_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) waitTimer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!timerEn),
        .countEn (timerEn),
        .expired (timerExpired)
    );

    // State register plus the trap cause. The cause is only sampled while
    // not trapped, so it freezes at the value chosen on entry to TRAP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            currentState <= FETCH;
            trapCause    <= 1'b0;
        end else begin
            currentState <= nextState;
            if (currentState != TRAP) begin
                trapCause <= nextCause;
            end
        end
    end

    // Control decode keyed on state. While reset is held every enable and
    // select is forced low so an in-flight request drops immediately.
    always_comb begin
        nextState    = currentState;
        nextCause    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_SEQ;
        reg_we       = 1'b0;
        reg_dst      = DST_RT;
        mem_to_reg   = WB_ALU;
        alu_src_a    = SRCA_REG;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        if (reset) begin
            if ((currentState == EXEC) || (currentState == MEM) || (currentState == WB)) begin
                alu_op    = aluOpFor(opcode, funct);
                alu_src_a = srcAFor(opcode);
                alu_src_b = srcBFor(opcode, funct);
            end
            case (currentState)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        nextState = DECODE;
                    end else if (timerExpired) begin
                        nextState = TRAP;
                        nextCause = 1'b1;
                    end
                end
                DECODE: begin
                    if (!isLegal(opcode, funct)) begin
                        nextState = TRAP;
                    end else if (opcode == OP_J) begin
                        pc_we     = 1'b1;
                        pc_src    = PC_SRC_JUMP;
                        nextState = FETCH;
                    end else if (opcode == OP_JAL) begin
                        pc_we      = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        reg_we     = 1'b1;
                        reg_dst    = DST_RA;
                        mem_to_reg = WB_PC4;
                        nextState  = FETCH;
                    end else begin
                        nextState = EXEC;
                    end
                end
                EXEC: begin
                    if (opcode == OP_BEQ) begin
                        pc_we     = zero;
                        pc_src    = PC_SRC_BRANCH;
                        nextState = FETCH;
                    end else if (opcode == OP_BNE) begin
                        pc_we     = !zero;
                        pc_src    = PC_SRC_BRANCH;
                        nextState = FETCH;
                    end else if (isRType && (funct == FN_JR)) begin
                        pc_we     = 1'b1;
                        pc_src    = PC_SRC_REG;
                        nextState = FETCH;
                    end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                        nextState = MEM;
                    end else begin
                        nextState = WB;
                    end
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OP_SW);
                    if (mem_ack) begin
                        nextState = (opcode == OP_SW) ? FETCH : WB;
                    end else if (timerExpired) begin
                        nextState = TRAP;
                        nextCause = 1'b1;
                    end
                end
                WB: begin
                    reg_we = 1'b1;
                    if (isRType) begin
                        reg_dst = DST_RD;
                    end else if (opcode == OP_LW) begin
                        mem_to_reg = WB_MEM;
                    end
                    nextState = FETCH;
                end
                TRAP: begin
                    nextState = TRAP;
                end
                default: begin
                    nextState = FETCH;
                end
            endcase
        end
    end

    assign busy       = (currentState != TRAP);
    assign trap       = (currentState == TRAP);
    assign trap_cause = trapCause;
    assign state      = STATE_W'(currentState);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// Each directed instruction is expanded by a small instruction-level model
// into the list of cycles it must take (inputs to drive plus expected
// outputs); one checker compares the DUT against that list every cycle.
module tb_mips_multicycle_ctrl;

    localparam int WAIT_MAX = 15;

    localparam int K_ILL  = 0;
    localparam int K_RALU = 1;
    localparam int K_JR   = 2;
    localparam int K_IALU = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_BNE  = 7;
    localparam int K_J    = 8;
    localparam int K_JAL  = 9;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irwe;
        logic       pcwe;
        logic [1:0] psrc;
        logic       rwe;
        logic [1:0] dst;
        logic [1:0] m2r;
        logic       busy;
        logic       trap;
        logic       cause;
    } ctl_t;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] srca;
        logic       srcb;
    } alu_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ack;
        logic       aluValid;
        ctl_t       ctl;
        alu_t       alu;
    } cyc_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a;
    logic       alu_src_b, busy, trap, trap_cause;
    logic [3:0] alu_op;
    logic [2:0] stateDbg;

    cyc_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cycleIdx = 0;

    always #5 clock = ~clock;

    mips_multicycle_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (8),
        .STATE_W  (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .reg_we       (reg_we),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .busy         (busy),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .state        (stateDbg)
    );

    // Instruction class and ULA setup straight from the instruction table.
    task automatic describe(input logic [5:0] op, input logic [5:0] fn,
                            output int kind, output logic [3:0] alu,
                            output logic [1:0] srca, output logic srcb);
        kind = K_ILL; alu = 4'h0; srca = 2'b00; srcb = 1'b0;
        case (op)
            6'h00: begin
                kind = K_RALU;
                case (fn)
                    6'h20: alu = 4'h0;
                    6'h22: alu = 4'h1;
                    6'h24: alu = 4'h2;
                    6'h25: alu = 4'h3;
                    6'h2A: alu = 4'h4;
                    6'h00: begin alu = 4'h5; srcb = 1'b1; end
                    6'h02: begin alu = 4'h6; srcb = 1'b1; end
                    6'h08: kind = K_JR;
                    default: kind = K_ILL;
                endcase
            end
            6'h02: kind = K_J;
            6'h03: kind = K_JAL;
            6'h04: begin kind = K_BEQ;  alu = 4'h1; srca = 2'b10; end
            6'h05: begin kind = K_BNE;  alu = 4'h1; srca = 2'b10; end
            6'h08: begin kind = K_IALU; alu = 4'h0; srca = 2'b10; end
            6'h0A: begin kind = K_IALU; alu = 4'h4; srca = 2'b10; end
            6'h0C: begin kind = K_IALU; alu = 4'h2; srca = 2'b01; end
            6'h0D: begin kind = K_IALU; alu = 4'h3; srca = 2'b01; end
            6'h0F: begin kind = K_IALU; alu = 4'h7; srca = 2'b01; end
            6'h23: begin kind = K_LW;   alu = 4'h0; srca = 2'b10; end
            6'h2B: begin kind = K_SW;   alu = 4'h0; srca = 2'b10; end
            default: kind = K_ILL;
        endcase
    endtask

    function automatic cyc_t blank(input logic [2:0] st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z);
        cyc_t c;
        c = '0;
        c.op = op; c.fn = fn; c.z = z;
        c.ctl.st = st;
        c.ctl.busy = 1'b1;
        return c;
    endfunction

    task automatic addTrap(input logic cause, input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        for (int i = 0; i < 3; i++) begin
            c = blank(3'd5, op, fn, 1'b0);
            c.ctl.busy = 1'b0; c.ctl.trap = 1'b1; c.ctl.cause = cause;
            q.push_back(c);
        end
    endtask

    task automatic addIdleFetch();
        cyc_t c;
        c = blank(3'd0, 6'h00, 6'h00, 1'b0);
        c.ctl.req = 1'b1;
        q.push_back(c);
    endtask

    // Expand one instruction into its expected cycles. fetchWait/memWait are
    // the number of wait states before ack; WAIT_MAX or more means no ack.
    task automatic addInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fetchWait, input int memWait, input logic strayAck);
        int kind; logic [3:0] alu; logic [1:0] sa; logic sb; cyc_t c;
        describe(op, fn, kind, alu, sa, sb);
        for (int i = 0; i <= fetchWait && i < WAIT_MAX; i++) begin
            c = blank(3'd0, op, fn, z);
            c.ctl.req = 1'b1;
            if (i == fetchWait) begin
                c.ack = 1'b1; c.ctl.irwe = 1'b1; c.ctl.pcwe = 1'b1;
            end
            q.push_back(c);
        end
        if (fetchWait >= WAIT_MAX) begin addTrap(1'b1, op, fn); return; end
        c = blank(3'd1, op, fn, z);
        c.ack = strayAck;
        if (kind == K_ILL) begin q.push_back(c); addTrap(1'b0, op, fn); return; end
        if (kind == K_J || kind == K_JAL) begin
            c.ctl.pcwe = 1'b1; c.ctl.psrc = 2'b10;
            if (kind == K_JAL) begin c.ctl.rwe = 1'b1; c.ctl.dst = 2'b10; c.ctl.m2r = 2'b10; end
            q.push_back(c);
            return;
        end
        q.push_back(c);
        c = blank(3'd2, op, fn, z);
        c.ack = strayAck;
        c.alu = {alu, sa, sb};
        c.aluValid = (kind != K_JR);
        if (kind == K_BEQ || kind == K_BNE || kind == K_JR) begin
            c.ctl.pcwe = (kind == K_JR) ? 1'b1 : ((kind == K_BEQ) ? z : !z);
            c.ctl.psrc = (kind == K_JR) ? 2'b11 : 2'b01;
            q.push_back(c);
            return;
        end
        q.push_back(c);
        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i <= memWait && i < WAIT_MAX; i++) begin
                c = blank(3'd3, op, fn, z);
                c.alu = {alu, sa, sb}; c.aluValid = 1'b1;
                c.ctl.req = 1'b1; c.ctl.asel = 1'b1; c.ctl.we = (kind == K_SW);
                c.ack = (i == memWait);
                q.push_back(c);
            end
            if (memWait >= WAIT_MAX) begin addTrap(1'b1, op, fn); return; end
            if (kind == K_SW) return;
        end
        c = blank(3'd4, op, fn, z);
        c.ack = strayAck;
        c.alu = {alu, sa, sb}; c.aluValid = 1'b1;
        c.ctl.rwe = 1'b1;
        c.ctl.dst = (kind == K_RALU) ? 2'b01 : 2'b00;
        c.ctl.m2r = (kind == K_LW) ? 2'b01 : 2'b00;
        q.push_back(c);
    endtask

    function automatic ctl_t sampleCtl();
        ctl_t a;
        a.st = stateDbg; a.req = mem_req; a.we = mem_we; a.asel = mem_addr_sel;
        a.irwe = ir_we; a.pcwe = pc_we; a.psrc = pc_src; a.rwe = reg_we;
        a.dst = reg_dst; a.m2r = mem_to_reg; a.busy = busy; a.trap = trap;
        a.cause = trap_cause;
        return a;
    endfunction

    task automatic checkOutput(input cyc_t c);
        ctl_t a; alu_t b;
        a = sampleCtl();
        b = {alu_op, alu_src_a, alu_src_b};
        checks++;
        if ((a == c.ctl) && (!c.aluValid || (b == c.alu))) passes++;
        else $display("[TB] FAIL cycle%0d: got ctl=%h alu=%h, expected ctl=%h alu=%h (alu checked=%0d)",
                      cycleIdx, a, b, c.ctl, c.alu, c.aluValid);
        cycleIdx++;
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkCtl(input string name, input ctl_t expected);
        ctl_t a;
        a = sampleCtl();
        checks++;
        if (a == expected) passes++;
        else $display("[TB] FAIL %s: got ctl=%h, expected ctl=%h", name, a, expected);
    endtask

    // Drives each queued cycle just after a rising edge, checks at the falling edge.
    task automatic applyStimulus();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; zero = c.z; mem_ack = c.ack;
            @(negedge clock);
            checkOutput(c);
            @(posedge clock);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic doReset();
        ctl_t e;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mem_ack = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        @(negedge clock);
        e = '0; e.busy = 1'b1;
        checkCtl("resetState", e);
        checkInt("resetAluSelects", int'({alu_op, alu_src_a, alu_src_b}), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ctl_t e;
        // add with zero wait states
        doReset();
        addInstr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
        checkInt("addCycles", q.size(), 4);
        checkInt("addWbDst", int'(q[3].ctl.dst), 1);
        checkInt("addWbAlu", int'(q[3].alu.alu), 0);
        addIdleFetch();
        applyStimulus();

        // lw with three memory wait states
        doReset();
        addInstr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
        checkInt("lwCycles", q.size(), 8);
        checkInt("lwWbM2r", int'(q[7].ctl.m2r), 1);
        addIdleFetch();
        applyStimulus();

        // sw, beq taken/not taken, jal, j
        doReset();
        addInstr(6'h2B, 6'h00, 1'b0, 0, 0, 1'b0);
        checkInt("swCycles", q.size(), 4);
        addInstr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
        checkInt("beqCycles", q.size(), 7);
        checkInt("beqTakenPcWe", int'(q[6].ctl.pcwe), 1);
        addInstr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
        addInstr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);
        checkInt("jalCycles", q.size(), 12);
        checkInt("jalDecodeCtl", int'(q[11].ctl), int'(18'b001_00001_10_1_10_10_100));
        addInstr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
        addIdleFetch();
        applyStimulus();

        // remaining decode set with fetch waits and stray acks
        doReset();
        addInstr(6'h00, 6'h22, 1'b0, 1, 0, 1'b1);
        addInstr(6'h00, 6'h24, 1'b0, 0, 0, 1'b0);
        addInstr(6'h00, 6'h25, 1'b1, 2, 0, 1'b1);
        addInstr(6'h00, 6'h2A, 1'b0, 0, 0, 1'b0);
        addInstr(6'h00, 6'h00, 1'b0, 0, 0, 1'b1);
        addInstr(6'h00, 6'h02, 1'b0, 0, 0, 1'b0);
        addInstr(6'h00, 6'h08, 1'b0, 0, 0, 1'b1);
        addInstr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0);
        addInstr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);
        addInstr(6'h08, 6'h00, 1'b0, 0, 0, 1'b0);
        addInstr(6'h0A, 6'h00, 1'b0, 1, 0, 1'b0);
        addInstr(6'h0C, 6'h00, 1'b0, 0, 0, 1'b1);
        addInstr(6'h0D, 6'h00, 1'b0, 0, 0, 1'b0);
        addInstr(6'h0F, 6'h00, 1'b0, 0, 0, 1'b0);
        addInstr(6'h2B, 6'h00, 1'b0, 0, 2, 1'b0);
        addInstr(6'h23, 6'h00, 1'b0, 14, 14, 1'b0);
        addIdleFetch();
        applyStimulus();

        // fetch never acked: timeout trap
        doReset();
        addInstr(6'h00, 6'h20, 1'b0, WAIT_MAX, 0, 1'b0);
        checkInt("fetchTimeoutCycles", q.size(), 18);
        applyStimulus();

        // memory never acked: timeout trap
        doReset();
        addInstr(6'h23, 6'h00, 1'b0, 0, WAIT_MAX, 1'b0);
        applyStimulus();

        // illegal opcode and unknown R-type funct
        doReset();
        addInstr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
        checkInt("illegalCycles", q.size(), 5);
        applyStimulus();
        doReset();
        addInstr(6'h00, 6'h3F, 1'b0, 0, 0, 1'b0);
        applyStimulus();

        // reset asserted mid-MEM
        doReset();
        addInstr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
        for (int i = 0; i < 4; i++) void'(q.pop_back());
        applyStimulus();
        #2;
        reset = 1'b0;
        #1;
        e = '0; e.busy = 1'b1;
        checkCtl("resetMidMem", e);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        e = '0; e.busy = 1'b1; e.req = 1'b1;
        checkCtl("fetchAfterReset", e);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
